// File: rtl/heap_range_tracker.sv
// heap_range_tracker: circular store of inclusive address ranges with a combinational hit
// query and a registered debug read port. Optional stats counters: HEAP_RANGE_TRACKER_STATS_EN.
module heap_range_tracker #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   en_write_i,
    input  logic [AW-1:0]          addr_first_i,
    input  logic [AW-1:0]          addr_last_i,
    input  logic [AW-1:0]          find_addr_i,
    output logic                   addr_in_range_o,
    input  logic [19:0]            read_index_i,
    output logic [31:0]            read_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]         valid;
    logic [DEPTH-1:0][AW-1:0] first, last;
    logic [PW-1:0]            wp, prev;
    logic [CW-1:0]            count;
    logic [DEPTH-1:0]         hit;
    logic                     bad, merge;
    logic [AW-1:0]            mfirst, mlast;
    logic [18:0]              ridx;
    logic [31:0]              rd;

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hit[i] = valid[i] && (first[i] <= find_addr_i) && (find_addr_i <= last[i]);
    end
    assign addr_in_range_o = |hit;

    // Only the most recent entry is a merge candidate; last+1 is widened so all-ones cannot wrap.
    assign prev   = wp - 1'b1;
    assign bad    = addr_first_i > addr_last_i;
    assign merge  = valid[prev]
                 && ({1'b0, addr_first_i} <= ({1'b0, last[prev]} + 1'b1))
                 && (addr_last_i >= first[prev]);
    assign mfirst = (addr_first_i < first[prev]) ? addr_first_i : first[prev];
    assign mlast  = (addr_last_i > last[prev]) ? addr_last_i : last[prev];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid  <= '0;
            first  <= '0;
            last   <= '0;
            wp     <= '0;
            count  <= '0;
            read_o <= '0;
        end else begin
            read_o <= rd;
            if (clear_i) begin
                valid <= '0;
                wp    <= '0;
                count <= '0;
            end else if (en_write_i && !bad) begin
                if (merge) begin
                    first[prev] <= mfirst;
                    last[prev]  <= mlast;
                end else begin
                    // When full this overwrites the oldest entry; no backpressure.
                    valid[wp] <= 1'b1;
                    first[wp] <= addr_first_i;
                    last[wp]  <= addr_last_i;
                    wp        <= wp + 1'b1;
                    if (count != CW'(DEPTH)) count <= count + 1'b1;
                end
            end
        end
    end

`ifdef HEAP_RANGE_TRACKER_STATS_EN
    logic [31:0] hit_cnt, ovw_cnt;
    logic        ovw;

    assign ovw = en_write_i && !bad && !merge && valid[wp];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt <= '0;
            ovw_cnt <= '0;
        end else if (clear_i) begin
            hit_cnt <= '0;
            ovw_cnt <= '0;
        end else begin
            if (addr_in_range_o && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (ovw && ovw_cnt != '1) ovw_cnt <= ovw_cnt + 1'b1;
        end
    end
`endif

    assign ridx = read_index_i[19:1];

    always_comb begin
        rd = '0;
        if (ridx < 19'(DEPTH) && valid[ridx[PW-1:0]])
            rd = read_index_i[0] ? 32'(last[ridx[PW-1:0]]) : 32'(first[ridx[PW-1:0]]);
`ifdef HEAP_RANGE_TRACKER_STATS_EN
        if (read_index_i == 20'hFFFFE) rd = hit_cnt;
        if (read_index_i == 20'hFFFFF) rd = ovw_cnt;
`endif
    end

    assign count_o = count;
    assign full_o  = (count == CW'(DEPTH));

endmodule

// File: tb/tb_heap_range_tracker.sv
// Bench for heap_range_tracker: directed steps then random traffic against a queue-based model.
module tb_heap_range_tracker;
    localparam int DEPTH = 8;
    localparam int AW    = 32;
`ifdef HEAP_RANGE_TRACKER_STATS_EN
    localparam logic [31:0] EXP_HITS = 32'd3;
    localparam logic [31:0] EXP_OVWS = 32'd1;
`else
    localparam logic [31:0] EXP_HITS = 32'd0;
    localparam logic [31:0] EXP_OVWS = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear, en_write;
    logic [AW-1:0] addr_first, addr_last, find_addr;
    logic          addr_in_range;
    logic [19:0]   read_index;
    logic [31:0]   read_data;
    logic [3:0]    count;
    logic          full;

    int checks = 0;
    int errors = 0;

    heap_range_tracker #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_write_i(en_write),
        .addr_first_i(addr_first), .addr_last_i(addr_last), .find_addr_i(find_addr),
        .addr_in_range_o(addr_in_range), .read_index_i(read_index), .read_o(read_data),
        .count_o(count), .full_o(full)
    );

    always #5 clk = ~clk;

    // Model: ranges oldest-first; slot of element j is (pushes - size + j) mod DEPTH.
    typedef struct { logic [31:0] f; logic [31:0] l; } rng_t;
    rng_t        mq[$];
    int          mn;
    logic [31:0] mhit, movw;

    function automatic logic model_hit(input logic [31:0] q);
        foreach (mq[j]) if (mq[j].f <= q && q <= mq[j].l) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [19:0] ri);
        int idx = int'(ri[19:1]);
`ifdef HEAP_RANGE_TRACKER_STATS_EN
        if (ri == 20'hFFFFE) return mhit;
        if (ri == 20'hFFFFF) return movw;
`endif
        if (idx >= DEPTH) return 32'd0;
        foreach (mq[j])
            if (((mn - mq.size() + j) % DEPTH) == idx) return ri[0] ? mq[j].l : mq[j].f;
        return 32'd0;
    endfunction

    task automatic model_write(input logic [31:0] f, input logic [31:0] l);
        rng_t r;
        if (f > l) return;
        if (mq.size() > 0 && longint'(f) <= longint'(mq[$].l) + 1 && l >= mq[$].f) begin
            if (f < mq[$].f) mq[$].f = f;
            if (l > mq[$].l) mq[$].l = l;
            return;
        end
        if (mq.size() == DEPTH) begin
            void'(mq.pop_front());
            movw++;
        end
        r.f = f;
        r.l = l;
        mq.push_back(r);
        mn++;
    endtask

    task automatic model_clear();
        mq.delete();
        mn   = 0;
        mhit = 0;
        movw = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, clock, check registered read.
    task automatic cyc(input logic wr, input logic [31:0] f, input logic [31:0] l,
                       input logic [31:0] q, input logic [19:0] ri, input logic clr);
        logic        ehit;
        logic [31:0] erd;
        en_write = wr; addr_first = f; addr_last = l;
        find_addr = q; read_index = ri; clear = clr;
        #1;
        ehit = model_hit(q);
        check("hit", {31'd0, addr_in_range}, {31'd0, ehit});
        check("count", {28'd0, count}, mq.size());
        check("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
        erd = model_read(ri);
        @(posedge clk);
        if (clr) model_clear();
        else begin
            if (ehit) mhit++;
            if (wr) model_write(f, l);
        end
        #1 check("read", read_data, erd);
        @(negedge clk);
    endtask

    // Combinational probe only; does not cross a clock edge (at most 3 per gap).
    task automatic peek(input string tag, input logic [31:0] q, input logic exp);
        en_write = 1'b0; clear = 1'b0; find_addr = q;
        #1 check(tag, {31'd0, addr_in_range}, {31'd0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_hit", {31'd0, addr_in_range}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_read", read_data, 32'd0);
        model_clear();
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] f, l, q;
        logic [19:0] ri;
        clear = 0; en_write = 0; addr_first = 0; addr_last = 0; find_addr = 0; read_index = 0;
        model_clear();
        @(negedge clk);
        do_reset();

        cyc(1, 32'h8000_1000, 32'h8000_100C, 32'h8000_1008, 20'd0, 0);
        peek("tp1_hit", 32'h8000_1008, 1'b1);
        peek("tp1_miss", 32'h8000_1010, 1'b0);
        check("tp1_count", {28'd0, count}, 32'd1);

        do_reset();
        cyc(1, 32'h2000, 32'h2004, 32'h0, 20'd0, 0);
        cyc(1, 32'h2005, 32'h2010, 32'h0, 20'd0, 0);
        cyc(0, 32'h0, 32'h0, 32'h0, 20'd0, 0);
        check("merge_first", read_data, 32'h2000);
        cyc(0, 32'h0, 32'h0, 32'h0, 20'd1, 0);
        check("merge_last", read_data, 32'h2010);
        check("merge_count", {28'd0, count}, 32'd1);

        cyc(1, 32'h300, 32'h200, 32'h0, 20'd1, 0);
        check("bad_count", {28'd0, count}, 32'd1);
        check("bad_last", read_data, 32'h2010);

        peek("pre_rst_hit", 32'h2008, 1'b1);
        do_reset();

        for (int k = 0; k < 9; k++)
            cyc(1, 32'h100 * k, 32'h100 * k + 4, 32'hFFFF_FFF0, 20'd0, 0);
        peek("wrap_old", 32'h2, 1'b0);
        peek("wrap_new", 32'h802, 1'b1);
        check("wrap_full", {31'd0, full}, 32'd1);
        check("wrap_count", {28'd0, count}, 32'd8);
        cyc(0, 0, 0, 32'h802, 20'd0, 0);
        cyc(0, 0, 0, 32'h702, 20'd0, 0);
        cyc(0, 0, 0, 32'h102, 20'd0, 0);
        cyc(0, 0, 0, 32'h2, 20'hFFFFE, 0);
        check("stat_hits", read_data, EXP_HITS);
        cyc(0, 0, 0, 32'h2, 20'hFFFFF, 0);
        check("stat_ovws", read_data, EXP_OVWS);

        cyc(1, 32'h400, 32'h404, 32'h0, 20'd0, 1);
        peek("clr_hit", 32'h402, 1'b0);
        check("clr_count", {28'd0, count}, 32'd0);

        cyc(1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0, 20'd0, 0);
        cyc(1, 32'h0, 32'h5, 32'hFFFF_FFFF, 20'd1, 0);
        cyc(1, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h3, 20'd2, 0);
        cyc(0, 0, 0, 32'hFFFF_FFF4, 20'd3, 0);

        for (int n = 0; n < 400; n++) begin
            f = $urandom_range(0, 96);
            l = f + $urandom_range(0, 10);
            if ($urandom_range(0, 9) == 0 && f > 0) l = f - 1;
            q = $urandom_range(0, 112);
            ri = ($urandom_range(0, 9) == 0) ? (20'hFFFFE | 20'($urandom_range(0, 1)))
                                             : 20'($urandom_range(0, 2 * DEPTH + 3));
            cyc($urandom_range(0, 9) < 6, f, l, q, ri, $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
